// File: rtl/sram_controller_if.sv
// rtl/sram_controller_if.sv - MEM-stage request/response bundle between pipeline and SRAM controller
//
// Signals:
//   rd_en       pipeline -> controller  load request (level)
//   wr_en       pipeline -> controller  store request (level)
//   address     pipeline -> controller  CPU byte address
//   write_data  pipeline -> controller  store data
//   read_data   controller -> pipeline  load data, registered
//   ready       controller -> pipeline  1 = no access pending, 0 = freeze pipeline
// Modports: master (MEM stage), slave (controller).
interface sram_controller_if #(
    parameter int WORD_WIDTH = 32
);
    logic                  rd_en;
    logic                  wr_en;
    logic [WORD_WIDTH-1:0] address;
    logic [WORD_WIDTH-1:0] write_data;
    logic [WORD_WIDTH-1:0] read_data;
    logic                  ready;

    modport master (
        output rd_en, wr_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  rd_en, wr_en, address, write_data,
        output read_data, ready
    );
endinterface

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - sequences a 32-bit load/store as two 16-bit off-chip SRAM accesses
//
// Ports:
//   clk        in     rising-edge clock
//   rst        in     asynchronous active-high reset
//   bus        slave  MEM-stage request/response (rd_en, wr_en, address, write_data, read_data, ready)
//   SRAM_DQ    inout  SRAM data bus, driven only while writing
//   SRAM_ADDR  out    SRAM half-word address
//   SRAM_WE_N  out    SRAM write enable, active-low
module sram_controller #(
    parameter int WORD_WIDTH      = 32,
    parameter int SRAM_DATA_WIDTH = 16,
    parameter int SRAM_ADDR_WIDTH = 18,
    parameter int BASE_ADDR       = 1024,
    parameter int ACCESS_CYCLES   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    sram_controller_if.slave           bus,
    inout  wire  [SRAM_DATA_WIDTH-1:0] SRAM_DQ,
    output logic [SRAM_ADDR_WIDTH-1:0] SRAM_ADDR,
    output logic                       SRAM_WE_N
);
    localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam int WW = SRAM_ADDR_WIDTH - 1;
    localparam int DW = SRAM_DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t                state, state_next;
    logic [CW-1:0]         counter;
    logic                  lat_wr;
    logic [WW-1:0]         lat_word;
    logic [WORD_WIDTH-1:0] lat_data;
    logic                  last_cycle;
    logic                  in_access;
    logic                  drive_dq;
    logic                  request;

    assign request    = bus.rd_en | bus.wr_en;
    assign last_cycle = (counter == CW'(ACCESS_CYCLES - 1));
    assign in_access  = (state == LO) || (state == HI);
    assign drive_dq   = in_access && lat_wr;

    // Address depends only on latched word and state, so it cannot glitch within LO/HI.
    assign SRAM_ADDR = {lat_word, (state == HI)};
    assign SRAM_WE_N = ~drive_dq;
    assign SRAM_DQ   = drive_dq ? ((state == HI) ? lat_data[2*DW-1:DW] : lat_data[DW-1:0])
                                : {DW{1'bz}};

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (request) state_next = LO;
            LO:      if (last_cycle) state_next = HI;
            HI:      if (last_cycle) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // rst term keeps ready high while reset is held even if a request is already up.
    always_comb begin
        bus.ready = 1'b1;
        case (state)
            IDLE:    bus.ready = rst | ~request;
            LO, HI:  bus.ready = 1'b0;
            default: bus.ready = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter       <= '0;
            lat_wr        <= 1'b0;
            lat_word      <= '0;
            lat_data      <= '0;
            bus.read_data <= '0;
        end else begin
            // Counter restarts on every state change so each half lasts exactly ACCESS_CYCLES.
            if (state_next != state || !in_access) begin
                counter <= '0;
            end else begin
                counter <= counter + 1'b1;
            end

            if (state == IDLE && request) begin
                lat_wr   <= bus.wr_en;
                lat_word <= WW'((bus.address - WORD_WIDTH'(BASE_ADDR)) >> 2);
                lat_data <= bus.write_data;
            end

            if (in_access && !lat_wr && last_cycle) begin
                if (state == LO) begin
                    bus.read_data[DW-1:0] <= SRAM_DQ;
                end else begin
                    bus.read_data[2*DW-1:DW] <= SRAM_DQ;
                end
            end
        end
    end
endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - directed-vector bench for sram_controller
module tb_sram_controller;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Default-timing controller with a small behavioural SRAM.
    sram_controller_if #(.WORD_WIDTH(32)) bus ();
    tri1 [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n;
    logic        sram_oe = 1'b0;
    logic [15:0] mem [0:15];

    sram_controller #(.ACCESS_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr), .SRAM_WE_N(sram_we_n)
    );

    assign sram_dq = (sram_oe && sram_we_n) ? mem[sram_addr[3:0]] : 16'hzzzz;
    always @(posedge clk) if (!sram_we_n) mem[sram_addr[3:0]] <= sram_dq;

    // Single-cycle-access controller; its SRAM returns the half-word address as data.
    sram_controller_if #(.WORD_WIDTH(32)) bus2 ();
    tri1 [15:0] sram_dq2;
    logic [17:0] sram_addr2;
    logic        sram_we_n2;

    sram_controller #(.ACCESS_CYCLES(1)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2),
        .SRAM_DQ(sram_dq2), .SRAM_ADDR(sram_addr2), .SRAM_WE_N(sram_we_n2)
    );

    assign sram_dq2 = sram_we_n2 ? (16'h1230 | {12'h0, sram_addr2[3:0]}) : 16'hzzzz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Runs one access starting at a negedge and holds the request until DONE.
    // Returns cycles with ready low, cycles with WE_N low, and the LO/HI addresses.
    task automatic access(input logic wr, input logic rd, input logic [31:0] addr,
                          input logic [31:0] data, output int low_cycles,
                          output int we_cycles, output logic [17:0] lo_a,
                          output logic [17:0] hi_a, output logic addr_stable);
        int n;
        logic [17:0] a [0:19];
        bus.wr_en = wr;
        bus.rd_en = rd;
        bus.address = addr;
        bus.write_data = data;
        n = 0;
        we_cycles = 0;
        #1;
        while (bus.ready == 1'b0 && n < 20) begin
            if (!sram_we_n) we_cycles++;
            a[n] = sram_addr;
            n++;
            @(negedge clk);
            #1;
        end
        if (n >= 20) check("ready_timeout", 32'(n), 32'd5);
        low_cycles = n;
        lo_a = a[1];
        hi_a = a[3];
        addr_stable = (a[1] == a[2]) && (a[3] == a[4]);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    int low, we;
    logic [17:0] lo_a, hi_a;
    logic stable;
    logic [7:0] pat;

    initial begin
        bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.address = '0; bus.write_data = '0;
        bus2.rd_en = 1'b0; bus2.wr_en = 1'b0; bus2.address = 32'd1024; bus2.write_data = '0;

        // 1: reset pulse mid-clock
        #3 rst = 1'b1;
        #1;
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_we_n", 32'(sram_we_n), 32'd1);
        check("rst_dq_z", 32'(sram_dq), 32'h0000ffff);
        check("rst_read_data", bus.read_data, 32'h0);
        check("rst_sram_addr", 32'(sram_addr), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 2: store
        access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, low, we, lo_a, hi_a, stable);
        check("st_ready_low", 32'(low), 32'd5);
        check("st_we_low", 32'(we), 32'd4);
        check("st_done_ready", 32'(bus.ready), 32'd1);
        check("st_done_we_n", 32'(sram_we_n), 32'd1);
        @(negedge clk);
        check("st_mem0", 32'(mem[0]), 32'h0000BEEF);
        check("st_mem1", 32'(mem[1]), 32'h0000DEAD);

        // 3: load
        sram_oe = 1'b1;
        access(1'b0, 1'b1, 32'd1024, 32'h0, low, we, lo_a, hi_a, stable);
        check("ld_ready_low", 32'(low), 32'd5);
        check("ld_we_low", 32'(we), 32'd0);
        check("ld_data", bus.read_data, 32'hDEADBEEF);
        sram_oe = 1'b0;
        @(negedge clk);

        // 4: mapping, bits 1:0 ignored
        access(1'b1, 1'b0, 32'd1028, 32'h11112222, low, we, lo_a, hi_a, stable);
        check("map1028_lo", 32'(lo_a), 32'd2);
        check("map1028_hi", 32'(hi_a), 32'd3);
        check("map1028_stable", 32'(stable), 32'd1);
        @(negedge clk);
        access(1'b1, 1'b0, 32'd1030, 32'h33334444, low, we, lo_a, hi_a, stable);
        check("map1030_lo", 32'(lo_a), 32'd2);
        check("map1030_hi", 32'(hi_a), 32'd3);
        check("read_data_hold", bus.read_data, 32'hDEADBEEF);
        @(negedge clk);

        // 5a: rd_en & wr_en executes as a write
        access(1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, low, we, lo_a, hi_a, stable);
        check("conf_we_low", 32'(we), 32'd4);
        @(negedge clk);
        check("conf_mem4", 32'(mem[4]), 32'h0000F00D);
        check("conf_mem5", 32'(mem[5]), 32'h0000CAFE);

        // 5b: reset during HI of a store
        bus.wr_en = 1'b1; bus.address = 32'd1024; bus.write_data = 32'h12345678;
        @(negedge clk); @(negedge clk); @(negedge clk);
        #1;
        check("abort_in_hi", 32'(sram_addr), 32'd1);
        rst = 1'b1;
        bus.wr_en = 1'b0;
        #1;
        check("abort_we_n", 32'(sram_we_n), 32'd1);
        check("abort_ready", 32'(bus.ready), 32'd1);
        check("abort_read_data", bus.read_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        sram_oe = 1'b1;
        access(1'b0, 1'b1, 32'd1024, 32'h0, low, we, lo_a, hi_a, stable);
        check("abort_load", bus.read_data, 32'hDEAD5678);
        sram_oe = 1'b0;
        @(negedge clk);

        // 6: ACCESS_CYCLES=1, back-to-back loads held asserted
        bus2.rd_en = 1'b1;
        pat = '0;
        #1;
        for (int i = 0; i < 8; i++) begin
            pat = {pat[6:0], bus2.ready};
            @(negedge clk);
            #1;
        end
        bus2.rd_en = 1'b0;
        check("ac1_ready_pattern", 32'(pat), 32'h00000011);
        check("ac1_read_data", bus2.read_data, 32'h12311230);
        check("ac1_we_n", 32'(sram_we_n2), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
